alu_control_unit: RTL and testbench

Registered ALU-control decoder for the single-cycle RV32I datapath. Maps the main decoder's 2-bit `alu_op` plus the instruction's `funct3`/`funct7` fields to the 4-bit operation select consumed by the ALU. It also flags illegal funct combinations to the control unit. Output is registered: one clock of latency from inputs to `alu_ctrl`.

---
 rtl/alu_control_unit.sv | 128 ++++++++++++
 tb/tb_alu_control_unit.sv | 137 +++++++++++++
 2 files changed

// File: rtl/alu_control_unit.sv
// alu_control_unit
//   Registered ALU-control decoder for the RV32I datapath. Turns the main
//   decoder's alu_op plus the instruction funct3/funct7 fields into the 4-bit
//   ALU operation select, and flags unsupported funct combinations.
//   One cycle of latency; a new decode is accepted every enabled cycle.
//
// Ports
//   clk       in   1  rising-edge clock
//   rst_n     in   1  asynchronous active-low reset
//   en        in   1  update enable (0 = outputs hold)
//   alu_op    in   2  00 ld/st addr, 01 branch cmp, 10 R-type, 11 I-type
//   funct3    in   3  instruction bits [14:12]
//   funct7    in   7  instruction bits [31:25]
//   alu_ctrl  out  4  registered ALU operation select
//   illegal   out  1  registered unsupported-combination flag
module alu_control_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_ctrl,
  output logic       illegal
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b0011;
  localparam logic [3:0] OP_SLTU = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b1000;
  localparam logic [3:0] OP_AND  = 4'b1001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [3:0] alu_ctrl_d, alu_ctrl_q;
  logic       illegal_d, illegal_q;

  logic f7_base, f7_alt;
  assign f7_base = (funct7 == F7_BASE);
  assign f7_alt  = (funct7 == F7_ALT);

  // Decode. alu_op is examined first so that for address/branch ops the
  // funct fields are never consulted (they may be undriven there).
  // Any illegal combination falls back to ADD with the flag set.
  always_comb begin
    alu_ctrl_d = OP_ADD;
    illegal_d  = 1'b0;
    case (alu_op)
      2'b00: alu_ctrl_d = OP_ADD;
      2'b01: alu_ctrl_d = OP_SUB;
      2'b10: begin
        case (funct3)
          3'b000: begin
            if (f7_base)     alu_ctrl_d = OP_ADD;
            else if (f7_alt) alu_ctrl_d = OP_SUB;
            else             illegal_d  = 1'b1;
          end
          3'b101: begin
            if (f7_base)     alu_ctrl_d = OP_SRL;
            else if (f7_alt) alu_ctrl_d = OP_SRA;
            else             illegal_d  = 1'b1;
          end
          default: begin
            // Remaining R-type ops have no alternate encoding.
            if (!f7_base) illegal_d = 1'b1;
            else begin
              case (funct3)
                3'b001:  alu_ctrl_d = OP_SLL;
                3'b010:  alu_ctrl_d = OP_SLT;
                3'b011:  alu_ctrl_d = OP_SLTU;
                3'b100:  alu_ctrl_d = OP_XOR;
                3'b110:  alu_ctrl_d = OP_OR;
                3'b111:  alu_ctrl_d = OP_AND;
                default: alu_ctrl_d = OP_ADD;
              endcase
            end
          end
        endcase
      end
      2'b11: begin
        // funct7 is immediate payload except for the shift encodings.
        case (funct3)
          3'b000: alu_ctrl_d = OP_ADD;
          3'b001: begin
            if (f7_base) alu_ctrl_d = OP_SLL;
            else         illegal_d  = 1'b1;
          end
          3'b010: alu_ctrl_d = OP_SLT;
          3'b011: alu_ctrl_d = OP_SLTU;
          3'b100: alu_ctrl_d = OP_XOR;
          3'b101: begin
            if (f7_base)     alu_ctrl_d = OP_SRL;
            else if (f7_alt) alu_ctrl_d = OP_SRA;
            else             illegal_d  = 1'b1;
          end
          3'b110: alu_ctrl_d = OP_OR;
          3'b111: alu_ctrl_d = OP_AND;
          default: illegal_d = 1'b1;
        endcase
      end
      default: begin
        alu_ctrl_d = OP_ADD;
        illegal_d  = 1'b0;
      end
    endcase
  end

  // Both outputs share one enable so they always move on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_ctrl_q <= OP_ADD;
      illegal_q  <= 1'b0;
    end else if (en) begin
      alu_ctrl_q <= alu_ctrl_d;
      illegal_q  <= illegal_d;
    end
  end

  assign alu_ctrl = alu_ctrl_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_alu_control_unit.sv
module tb_alu_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] alu_op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [3:0] alu_ctrl;
  logic       illegal;

  typedef struct {
    logic [3:0] ctrl;
    logic       ill;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  bit   done    = 1'b0;

  alu_control_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .alu_op   (alu_op),
    .funct3   (funct3),
    .funct7   (funct7),
    .alu_ctrl (alu_ctrl),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] ctrl, input logic ill);
    n_total++;
    if (alu_ctrl === ctrl && illegal === ill) n_pass++;
    else $display("FAIL %s: got ctrl=%b ill=%b, want ctrl=%b ill=%b",
                  name, alu_ctrl, illegal, ctrl, ill);
  endtask

  // Drive one vector at the falling edge; its result is due after the next rising edge.
  task automatic step(input string name, input logic [1:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic e,
                      input logic [3:0] ctrl, input logic ill);
    exp_t x;
    @(negedge clk);
    alu_op = op; funct3 = f3; funct7 = f7; en = e;
    x.ctrl = ctrl; x.ill = ill; x.name = name;
    exp_q.push_back(x);
  endtask

  // Monitor: one expectation retires per rising edge, sampled 1 time unit later.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      check(x.name, x.ctrl, x.ill);
    end
  end

  initial begin
    #100000;
    if (!done) begin
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "timeout");
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b1;
    alu_op = 2'b10; funct3 = 3'b011; funct7 = 7'b0100000;
    #2;
    check("reset_before_edge", 4'b0000, 1'b0);
    @(posedge clk); #1;
    check("reset_held_over_edge", 4'b0000, 1'b0);

    @(negedge clk); rst_n = 1'b1;
    step("first_after_reset_sub", 2'b01, 3'b000, 7'b0, 1'b1, 4'b0001, 1'b0);

    step("ldst_x_funct", 2'b00, 3'bxxx, 7'bxxxxxxx, 1'b1, 4'b0000, 1'b0);
    step("branch_x_funct", 2'b01, 3'bxxx, 7'bxxxxxxx, 1'b1, 4'b0001, 1'b0);

    step("r_add",  2'b10, 3'b000, 7'b0000000, 1'b1, 4'b0000, 1'b0);
    step("r_sll",  2'b10, 3'b001, 7'b0000000, 1'b1, 4'b0010, 1'b0);
    step("r_slt",  2'b10, 3'b010, 7'b0000000, 1'b1, 4'b0011, 1'b0);
    step("r_sltu", 2'b10, 3'b011, 7'b0000000, 1'b1, 4'b0100, 1'b0);
    step("r_xor",  2'b10, 3'b100, 7'b0000000, 1'b1, 4'b0101, 1'b0);
    step("r_srl",  2'b10, 3'b101, 7'b0000000, 1'b1, 4'b0110, 1'b0);
    step("r_or",   2'b10, 3'b110, 7'b0000000, 1'b1, 4'b1000, 1'b0);
    step("r_and",  2'b10, 3'b111, 7'b0000000, 1'b1, 4'b1001, 1'b0);

    step("r_sub",        2'b10, 3'b000, 7'b0100000, 1'b1, 4'b0001, 1'b0);
    step("r_sra",        2'b10, 3'b101, 7'b0100000, 1'b1, 4'b0111, 1'b0);
    step("r_xor_alt_ill",2'b10, 3'b100, 7'b0100000, 1'b1, 4'b0000, 1'b1);
    step("r_add_f7_ill", 2'b10, 3'b000, 7'b0000001, 1'b1, 4'b0000, 1'b1);
    step("r_and_alt_ill",2'b10, 3'b111, 7'b0100000, 1'b1, 4'b0000, 1'b1);

    step("i_add_alt",    2'b11, 3'b000, 7'b0100000, 1'b1, 4'b0000, 1'b0);
    step("i_sra",        2'b11, 3'b101, 7'b0100000, 1'b1, 4'b0111, 1'b0);
    step("i_srl",        2'b11, 3'b101, 7'b0000000, 1'b1, 4'b0110, 1'b0);
    step("i_sll_ill",    2'b11, 3'b001, 7'b0000001, 1'b1, 4'b0000, 1'b1);
    step("i_sll",        2'b11, 3'b001, 7'b0000000, 1'b1, 4'b0010, 1'b0);
    step("i_slt_imm",    2'b11, 3'b010, 7'b1111111, 1'b1, 4'b0011, 1'b0);
    step("i_sltu_imm",   2'b11, 3'b011, 7'b0100000, 1'b1, 4'b0100, 1'b0);
    step("i_shr_ill",    2'b11, 3'b101, 7'b0000001, 1'b1, 4'b0000, 1'b1);

    step("hold_load_xor", 2'b10, 3'b100, 7'b0000000, 1'b1, 4'b0101, 1'b0);
    step("hold_en0_a",    2'b10, 3'b000, 7'b0100000, 1'b0, 4'b0101, 1'b0);
    step("hold_en0_ill",  2'b10, 3'b100, 7'b0100000, 1'b0, 4'b0101, 1'b0);
    step("hold_en1_sub",  2'b10, 3'b000, 7'b0100000, 1'b1, 4'b0001, 1'b0);

    // Async reset between edges: outputs clear before the next rising edge.
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_midcycle", 4'b0000, 1'b0);
    @(posedge clk); #1;
    check("async_reset_no_glitch", 4'b0000, 1'b0);

    @(negedge clk); rst_n = 1'b1;
    step("post_reset_and", 2'b11, 3'b111, 7'b0000000, 1'b1, 4'b1001, 1'b0);

    @(negedge clk);
    @(negedge clk);
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending, want 0", exp_q.size());

    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
